ghash_rtab_lookup_arbiter: RTL and testbench

Shares a single GHASH reduction table (256 entries × 16 bits, the Shoup 8-bit R table) between several requesters, e.g. parallel GHASH byte-reduction lanes. Each cycle the block arbitrates pending lookups, grants at most one, and returns the registered table word with a one-hot acknowledge one cycle later. The output stage supports backpressure. The block instantiates the table generator internally and counts accepted lookups for performance monitoring.

---
 rtl/ghash_rtab_lookup_arbiter.sv | 157 +++++++++++++++
 tb/tb_ghash_rtab_lookup_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_rtab_lookup_arbiter.sv
// ghash_rtab_lookup_arbiter
//   Shares one combinational GHASH 8-bit reduction table (Shoup R table)
//   between N_REQ requesters. Each cycle at most one pending lookup is
//   granted. The table word and a one-hot acknowledge are registered and
//   appear one cycle later. The output register honours downstream
//   backpressure. Accepted lookups are counted in a wrapping 16-bit counter.
//
// Build option:
//   GHASH_RTAB_ARB_RR_EN  defined   -> round-robin arbitration
//                         undefined -> fixed priority, lowest index wins
//
// Ports:
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous reset, active low
//   i_req    : [N_REQ] per-requester request, held until granted
//   i_index  : [N_REQ*NB_BYTE] lookup indices, requester k at [k*NB_BYTE +: NB_BYTE]
//   i_ready  : downstream accepts o_data this cycle
//   o_gnt    : [N_REQ] combinational one-hot grant
//   o_valid  : o_data / o_ack valid
//   o_data   : [2*NB_BYTE] registered R[index] of the granted request
//   o_ack    : [N_REQ] registered one-hot owner of o_data, 0 when not valid
//   o_count  : [16] accepted-lookup counter, wraps

// Combinational R table: bit b of the index contributes POLY >> b.
module ghash_rtab_gen #(
    parameter int NB_BYTE = 8
) (
    input  logic [NB_BYTE-1:0]   idx_i,
    output logic [2*NB_BYTE-1:0] r_o
);
    localparam int DW = 2 * NB_BYTE;
    localparam logic [DW-1:0] POLY = {8'hE1, {(DW-8){1'b0}}};

    always_comb begin
        r_o = '0;
        for (int b = 0; b < NB_BYTE; b++) begin
            if (idx_i[b]) r_o = r_o ^ (POLY >> b);
        end
    end
endmodule

module ghash_rtab_lookup_arbiter #(
    parameter int NB_BYTE = 8,
    parameter int N_REQ   = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_BYTE-1:0] i_index,
    input  logic                     i_ready,
    output logic [N_REQ-1:0]         o_gnt,
    output logic                     o_valid,
    output logic [2*NB_BYTE-1:0]     o_data,
    output logic [N_REQ-1:0]         o_ack,
    output logic [15:0]              o_count
);
    localparam int DW = 2 * NB_BYTE;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic                valid_q, valid_d;
    logic [DW-1:0]       data_q, data_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [15:0]         count_q, count_d;
    logic                accept;
    logic [N_REQ-1:0]    pick;
    logic [N_REQ-1:0]    lowest;
    logic [NB_BYTE-1:0]  sel_idx;
    logic [DW-1:0]       tab_word;

    // The output register can take a new word when empty or being drained.
    assign accept = (~valid_q | i_ready) & (|i_req) & i_reset;

`ifdef GHASH_RTAB_ARB_RR_EN
    localparam int PW = $clog2(N_REQ);
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] req_hi;
    logic [PW-1:0]    win_idx;

    // Requesters above the pointer go first; if none are pending the
    // search wraps to the full request vector.
    for (genvar k = 0; k < N_REQ; k++) begin : g_mask
        assign hi_mask[k] = (PW'(k) > ptr_q);
    end
    assign req_hi = i_req & hi_mask;
    assign pick   = (|req_hi) ? req_hi : i_req;

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_gnt[k]) win_idx = PW'(k);
        end
    end

    // Pointer only moves on accept, so it holds through backpressure.
    assign ptr_d = accept ? win_idx : ptr_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) ptr_q <= PW'(N_REQ - 1);
        else          ptr_q <= ptr_d;
    end
`else
    assign pick = i_req;
`endif

    // Isolate the lowest set bit of the candidate vector.
    assign lowest = pick & (~pick + ONE);
    assign o_gnt  = accept ? lowest : '0;

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_gnt[k]) sel_idx = sel_idx | i_index[k*NB_BYTE +: NB_BYTE];
        end
    end

    ghash_rtab_gen #(.NB_BYTE(NB_BYTE)) u_rtab (
        .idx_i (sel_idx),
        .r_o   (tab_word)
    );

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ack_d   = ack_q;
        count_d = count_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = tab_word;
            ack_d   = o_gnt;
            count_d = count_q + 16'd1;
        end else if (i_ready) begin
            // Drained with nothing to replace it; o_data keeps its last value.
            valid_d = 1'b0;
            ack_d   = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            count_q <= count_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_ack   = ack_q;
    assign o_count = count_q;
endmodule

// File: tb/tb_ghash_rtab_lookup_arbiter.sv
module tb_ghash_rtab_lookup_arbiter;
    localparam int NB = 8;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*NB-1:0] idx = '0;
    logic          rdy = 1'b0;
    logic [N-1:0]  o_gnt;
    logic          o_valid;
    logic [15:0]   o_data;
    logic [N-1:0]  o_ack;
    logic [15:0]   o_count;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [15:0]  rtab [256];
    bit           m_valid;
    logic [15:0]  m_data;
    logic [N-1:0] m_ack;
    logic [15:0]  m_count;
    int           m_ptr;
    logic [N-1:0] g_last;

    ghash_rtab_lookup_arbiter #(.NB_BYTE(NB), .N_REQ(N)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .i_req   (req),
        .i_index (idx),
        .i_ready (rdy),
        .o_gnt   (o_gnt),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ack   (o_ack),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Table built by linearity: R[i] = R[i without lowest bit] ^ (0xE100 >> lowest bit).
    task automatic build_table();
        rtab[0] = 16'h0000;
        for (int i = 1; i < 256; i++) begin
            int b;
            b = 0;
            while (((i >> b) & 1) == 0) b++;
            rtab[i] = rtab[i & (i - 1)] ^ (16'hE100 >> b);
        end
    endtask

    function automatic logic [N-1:0] ref_gnt(input logic [N-1:0] r, input int ptr, input bit acc);
        logic [N-1:0] g;
        g = '0;
        if (acc) begin
`ifdef GHASH_RTAB_ARB_RR_EN
            for (int j = 1; j <= N; j++) begin
                int k;
                k = (ptr + j) % N;
                if (r[k] && g == 0) g[k] = 1'b1;
            end
`else
            for (int k = 0; k < N; k++)
                if (r[k] && g == 0) g[k] = 1'b1;
`endif
        end
        return g;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 16'h0;
        m_ack   = '0;
        m_count = 16'h0;
        m_ptr   = N - 1;
        g_last  = '0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cyc();
        bit acc;
        logic [N-1:0] g;
        int w;
        #1;
        acc = (!m_valid || rdy) && (req != 0) && rst_n;
        g = ref_gnt(req, m_ptr, acc);
        chk("gnt", {28'h0, o_gnt}, {28'h0, g});
        g_last = g;
        w = 0;
        for (int k = 0; k < N; k++) if (g[k]) w = k;
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_data  = rtab[idx[w*NB +: NB]];
            m_ack   = g;
            m_count = m_count + 16'd1;
            m_ptr   = w;
        end else if (rdy) begin
            m_valid = 1'b0;
            m_ack   = '0;
        end
        #1;
        chk("valid", {31'h0, o_valid}, {31'h0, m_valid});
        chk("ack",   {28'h0, o_ack},   {28'h0, m_ack});
        chk("data",  {16'h0, o_data},  {16'h0, m_data});
        chk("count", {16'h0, o_count}, {16'h0, m_count});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0]  hold_data;
    logic [N-1:0] hold_ack;
    logic [N-1:0] exp_seq [5];

    initial begin
        build_table();
        model_reset();

        // Reset state, with a request present so o_gnt masking is exercised.
        rst_n = 1'b0; req = 4'b0001; idx = 32'h0000_0001; rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_data",  {16'h0, o_data},  32'h0);
        chk("rst_ack",   {28'h0, o_ack},   32'h0);
        chk("rst_count", {16'h0, o_count}, 32'h0);
        chk("rst_gnt",   {28'h0, o_gnt},   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single lookup on requester 0, index 0x01.
        cyc();
        chk("t1_gnt",   {28'h0, g_last},  32'h1);
        chk("t1_data",  {16'h0, o_data},  32'hE100);
        chk("t1_ack",   {28'h0, o_ack},   32'h1);
        chk("t1_count", {16'h0, o_count}, 32'h1);

        // Back-to-back on requester 2.
        do_reset();
        req = 4'b0100; rdy = 1'b1;
        idx = 32'h0080_0000; cyc(); chk("t2_d80", {16'h0, o_data}, 32'h01C2);
        idx = 32'h00FF_0000; cyc(); chk("t2_dFF", {16'h0, o_data}, 32'hBEBE);
        idx = 32'h0000_0000; cyc(); chk("t2_d00", {16'h0, o_data}, 32'h0000);
        chk("t2_valid", {31'h0, o_valid}, 32'h1);
        chk("t2_count", {16'h0, o_count}, 32'h3);

        // All four requesting continuously.
`ifdef GHASH_RTAB_ARB_RR_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        do_reset();
        req = 4'b1111; idx = 32'h0303_0303; rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_order", {28'h0, g_last}, {28'h0, exp_seq[i]});
            chk("t3_data",  {16'h0, o_data}, 32'h9180);
        end

        // Backpressure: output held, no grants, then resume without a bubble.
        hold_data = o_data; hold_ack = o_ack;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_gnt",  {28'h0, g_last}, 32'h0);
            chk("bp_data", {16'h0, o_data}, {16'h0, hold_data});
            chk("bp_ack",  {28'h0, o_ack},  {28'h0, hold_ack});
        end
        rdy = 1'b1;
        cyc();
`ifdef GHASH_RTAB_ARB_RR_EN
        chk("bp_resume", {28'h0, o_ack}, 32'h2);
`else
        chk("bp_resume", {28'h0, o_ack}, 32'h1);
`endif
        chk("bp_count", {16'h0, o_count}, 32'h6);

        // Asynchronous reset mid-cycle while valid with requests pending.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'h0, o_valid}, 32'h0);
        chk("ar_ack",   {28'h0, o_ack},   32'h0);
        chk("ar_count", {16'h0, o_count}, 32'h0);
        chk("ar_gnt",   {28'h0, o_gnt},   32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("ar_first", {28'h0, o_ack}, 32'h1);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (g_last[k]) begin
                    if ($urandom_range(0, 3) != 0) req[k] = 1'b0;
                end else if (!req[k]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req[k] = 1'b1;
                        idx[k*NB +: NB] = 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req[k] = 1'b0;
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            cyc();
        end

        // Counter wrap.
        do_reset();
        req = 4'b0001; idx = {24'h0, 8'($urandom_range(0, 255))}; rdy = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", {16'h0, o_count}, 32'hFFFF);
        m_valid = 1'b1; m_ack = 4'b0001; m_data = rtab[idx[7:0]];
        m_count = 16'hFFFF; m_ptr = 0;
        @(negedge clk);
        cyc();
        chk("wrap_zero", {16'h0, o_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
